// File: rtl/halflife_pkg.sv
// Shared types and helpers for the half-life timer UART reporter.
package halflife_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Uppercase hex digit for a 4-bit value.
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
    logic [3:0] off;
    if (nib < 4'd10) begin
      return ASCII_0 + {4'h0, nib};
    end else begin
      off = nib - 4'd10;
      return ASCII_A + {4'h0, off};
    end
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A byte is accepted whenever start and ready are both high;
// ready is also raised in the last stop-bit cycle so frames can be chained back to back.
module uart_tx_byte
  import halflife_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLK_DIV);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shreg_q;
  logic             tick;
  logic             load;

  assign tick  = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign ready = (state_q == IDLE) || ((state_q == STOP) && tick);
  assign load  = start && ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The baud counter rests at zero in IDLE so every frame starts phase-aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '1;
    end else begin
      if ((state_q == IDLE) || tick) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (load) begin
        shreg_q <= data;
        bit_q   <= '0;
      end else if ((state_q == DATA) && tick) begin
        shreg_q <= {1'b1, shreg_q[7:1]};
        bit_q   <= bit_q + 3'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = START;
      START:   if (tick) state_d = DATA;
      DATA:    if (tick && (bit_q == 3'd7)) state_d = STOP;
      STOP:    if (tick) state_d = start ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx   = 1'b1;
    busy = 1'b1;
    case (state_q)
      IDLE:    busy = 1'b0;
      START:   tx = 1'b0;
      DATA:    tx = shreg_q[0];
      STOP:    tx = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: rtl/halflife_uart_tx.sv
// Reports every change of the timer count as an ASCII hex char (plus optional LF)
// over a UART line; tracks a single pending report and flags overwrites.
module halflife_uart_tx
  import halflife_pkg::*;
#(
  parameter int CLK_DIV   = 434,
  parameter bit APPEND_LF = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] value,
  input  logic       force_tx,
  output logic       tx,
  output logic       busy,
  output logic       overrun
);

  logic [3:0] last_q;
  logic [3:0] pend_val_q;
  logic       pend_q;
  logic       lf_due_q;
  logic       overrun_q;
  logic       capture;
  logic       take_hex;
  logic       take_lf;
  logic       byte_start;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       byte_busy;

  assign capture = (value != last_q) || force_tx;

  // New reports only start from IDLE; the LF is chained onto the stop bit of the hex char.
  assign take_hex   = !lf_due_q && pend_q && !byte_busy;
  assign take_lf    = lf_due_q && byte_ready;
  assign byte_start = take_hex || take_lf;
  assign byte_data  = lf_due_q ? ASCII_LF : hex_to_ascii(pend_val_q);

  // A pending report consumed at the same edge has started, so it is not an overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q     <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      lf_due_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= capture && pend_q && !take_hex;
      if (capture) begin
        last_q     <= value;
        pend_val_q <= value;
        pend_q     <= 1'b1;
      end else if (take_hex) begin
        pend_q <= 1'b0;
      end
      if (take_hex) begin
        lf_due_q <= APPEND_LF;
      end else if (take_lf) begin
        lf_due_q <= 1'b0;
      end
    end
  end

  uart_tx_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_byte (
    .clk  (clk),
    .reset(reset),
    .start(byte_start),
    .data (byte_data),
    .ready(byte_ready),
    .tx   (tx),
    .busy (byte_busy)
  );

  assign busy    = byte_busy;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_halflife_uart_tx.sv
// Directed bench for halflife_uart_tx with CLK_DIV = 4; a second instance runs without LF.
module tb_halflife_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] value;
  logic       force_tx;
  logic       tx, busy, overrun;
  logic       tx2, busy2, overrun2;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  int busy2_cnt = 0;
  int ovr_cnt = 0;
  int tx_low_cnt = 0;

  always #5 clk = ~clk;

  halflife_uart_tx #(.CLK_DIV(4), .APPEND_LF(1'b1)) dut (
    .clk(clk), .reset(reset), .value(value), .force_tx(force_tx),
    .tx(tx), .busy(busy), .overrun(overrun)
  );

  halflife_uart_tx #(.CLK_DIV(4), .APPEND_LF(1'b0)) dut_nolf (
    .clk(clk), .reset(reset), .value(value), .force_tx(force_tx),
    .tx(tx2), .busy(busy2), .overrun(overrun2)
  );

  // Free-running activity counters; scenarios compare differences across a window.
  always @(posedge clk) begin
    if (busy) busy_cnt <= busy_cnt + 1;
    if (busy2) busy2_cnt <= busy2_cnt + 1;
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (!tx) tx_low_cnt <= tx_low_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [3:0] val, input logic frc);
    reset    = rst;
    value    = val;
    force_tx = frc;
  endtask

  // Called at the first negedge of the start bit; leaves off at the first negedge after the frame.
  task automatic checkFrame(input bit sel, input logic [7:0] ch, input string tag);
    logic [9:0] bits;
    bits = {1'b1, ch, 1'b0};
    for (int b = 0; b < 10; b++) begin
      checkOutput($sformatf("%s_bit%0d", tag, b), sel ? tx2 : tx, bits[b]);
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, (n < 1000) ? 1 : 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b0, b20, o0, t0;

    // Reset state
    applyStimulus(1'b1, 4'h0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("rst_tx", tx, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_tx_nolf", tx2, 1);

    // Idle with value held at zero
    applyStimulus(1'b0, 4'h0, 1'b0);
    b0 = busy_cnt; o0 = ovr_cnt; t0 = tx_low_cnt;
    repeat (200) @(negedge clk);
    checkOutput("idle_tx_low", tx_low_cnt - t0, 0);
    checkOutput("idle_busy", busy_cnt - b0, 0);
    checkOutput("idle_overrun", ovr_cnt - o0, 0);

    // Single report of 0xA, with the no-LF instance sending 'A' alone
    applyStimulus(1'b0, 4'hA, 1'b0);
    @(negedge clk);
    checkOutput("single_lat_tx", tx, 1);
    checkOutput("single_lat_busy", busy, 0);
    b0 = busy_cnt; b20 = busy2_cnt;
    @(negedge clk);
    checkOutput("single_busy_rise", busy, 1);
    checkFrame(1'b0, 8'h41, "single_hex");
    checkFrame(1'b0, 8'h0A, "single_lf");
    checkOutput("single_busy_fall", busy, 0);
    checkOutput("single_busy_len", busy_cnt - b0, 80);
    checkOutput("nolf_busy_len_a", busy2_cnt - b20, 40);

    // Overrun: 3 is overwritten by 7 before it ever starts
    repeat (3) @(negedge clk);
    o0 = ovr_cnt;
    applyStimulus(1'b0, 4'h1, 1'b0);
    repeat (10) @(negedge clk);
    applyStimulus(1'b0, 4'h3, 1'b0);
    @(negedge clk);
    checkOutput("ovr_first_capture", overrun, 0);
    repeat (5) @(negedge clk);
    applyStimulus(1'b0, 4'h7, 1'b0);
    @(negedge clk);
    checkOutput("ovr_pulse", overrun, 1);
    @(negedge clk);
    checkOutput("ovr_pulse_end", overrun, 0);
    waitIdle("ovr_wait1");
    checkOutput("ovr_gap_tx", tx, 1);
    checkOutput("ovr_count", ovr_cnt - o0, 1);
    @(negedge clk);
    checkFrame(1'b0, 8'h37, "ovr_hex7");
    checkFrame(1'b0, 8'h0A, "ovr_lf");
    checkOutput("ovr_no_third", busy, 0);

    // Force: one-cycle pulse gives exactly one report
    applyStimulus(1'b1, 4'h5, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 4'h5, 1'b0);
    repeat (3) @(negedge clk);
    waitIdle("force_wait_init");
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 4'h5, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 4'h5, 1'b0);
    checkOutput("force_lat_busy", busy, 0);
    @(negedge clk);
    checkFrame(1'b0, 8'h35, "force_hex5");
    checkFrame(1'b0, 8'h0A, "force_lf");
    b0 = busy_cnt;
    repeat (10) @(negedge clk);
    checkOutput("force_once", busy_cnt - b0, 0);

    // Force held three cycles: one overrun pulse
    o0 = ovr_cnt;
    applyStimulus(1'b0, 4'h5, 1'b1);
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 4'h5, 1'b0);
    checkOutput("force3_pulse", overrun, 1);
    repeat (2) @(negedge clk);
    checkOutput("force3_count", ovr_cnt - o0, 1);

    // Reset mid-frame while sending 9, then a fresh full report
    applyStimulus(1'b1, 4'h9, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 4'h9, 1'b0);
    @(negedge clk);
    checkOutput("rstmid_capture_tx", tx, 1);
    @(negedge clk);
    checkOutput("rstmid_start_tx", tx, 0);
    repeat (12) @(negedge clk);
    checkOutput("rstmid_in_frame", busy, 1);
    applyStimulus(1'b1, 4'h9, 1'b0);
    @(negedge clk);
    checkOutput("rstmid_tx", tx, 1);
    checkOutput("rstmid_busy", busy, 0);
    checkOutput("rstmid_busy_nolf", busy2, 0);
    applyStimulus(1'b0, 4'h9, 1'b0);
    @(negedge clk);
    checkOutput("rstmid_relat_tx", tx, 1);
    @(negedge clk);
    checkFrame(1'b0, 8'h39, "rstmid_hex9");
    checkFrame(1'b0, 8'h0A, "rstmid_lf");
    checkOutput("rstmid_done", busy, 0);

    // No LF: change to 0xF on the no-LF instance
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 4'hF, 1'b0);
    @(negedge clk);
    b20 = busy2_cnt;
    @(negedge clk);
    checkFrame(1'b1, 8'h46, "nolf_hexF");
    checkOutput("nolf_busy_fall", busy2, 0);
    checkOutput("nolf_busy_len", busy2_cnt - b20, 40);
    waitIdle("final_wait");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
